// File: rtl/vdu_ste_pkg.sv
// Shared constants, FSM state type and status-byte packing for the VDU STEbus slave.
`timescale 1ns/1ps
package vdu_ste_pkg;

    localparam logic [2:0] CM_IO         = 3'b100;
    localparam int         CM_RD_BIT     = 0;
    localparam logic [2:0] STATUS_OFFSET = 3'd7;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_COUNT_LSB = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WAIT_ROOM = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_RELEASE   = 3'd4
    } state_t;

    function automatic logic [7:0] status_byte(input logic [2:0] cnt,
                                               input logic       full,
                                               input logic       empty);
        logic [7:0] s;
        s                         = 8'h00;
        s[STAT_COUNT_LSB +: 3]    = cnt;
        s[STAT_FULL_BIT]          = full;
        s[STAT_EMPTY_BIT]         = empty;
        return s;
    endfunction

endpackage

// File: rtl/vdu_ste_if.sv
// Bus-side and controller-side signal bundle of the VDU STEbus slave.
`timescale 1ns/1ps
interface vdu_ste_if;
    logic        adrstb_n;
    logic        datstb_n;
    logic [2:0]  cm;
    logic [11:0] addr;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        cs;
    logic        wr_valid;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;

    modport slave (
        input  adrstb_n, datstb_n, cm, addr, d_in, wr_ready, rd_data,
        output d_out, d_oe, cs, wr_valid, wr_addr, wr_data, rd_addr
    );

    modport master (
        output adrstb_n, datstb_n, cm, addr, d_in, wr_ready, rd_data,
        input  d_out, d_oe, cs, wr_valid, wr_addr, wr_data, rd_addr
    );
endinterface

// File: rtl/vdu_ste_fifo.sv
// Synchronous circular-buffer FIFO with push, pop and a flush that overrides both.
`timescale 1ns/1ps
module vdu_ste_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/vdu_ste_slave.sv
// STEbus slave front end for the VDU card: I/O decode, write queue, register reads and cycle stretch.
`timescale 1ns/1ps
module vdu_ste_slave
    import vdu_ste_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = 12'h0A0,
    parameter int          FIFO_DEPTH = 4
) (
    input logic     clk,
    input logic     rst_n,
    vdu_ste_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        adr_s1_r, adr_s2_r;
    logic        ds1_r, ds2_r, ds3_r;
    logic        fall_r;
    state_t      state_r;
    logic        cs_r;
    logic        d_oe_r;
    logic [7:0]  d_out_r;
    logic [2:0]  rd_addr_r;
    logic [2:0]  pend_off_r;
    logic [7:0]  pend_data_r;

    logic        hit_s;
    logic        is_rd_s;
    logic [2:0]  off_s;
    logic        push_s;
    logic        flush_s;
    logic        pop_s;
    logic [10:0] push_word_s;
    logic [10:0] head_s;
    logic [CW-1:0] count_s;
    logic        full_s;
    logic        empty_s;
    logic [7:0]  status_s;

    assign off_s    = bus.addr[2:0];
    assign is_rd_s  = bus.cm[CM_RD_BIT];
    assign hit_s    = ~adr_s2_r && (bus.cm[2:1] == CM_IO[2:1]) &&
                      (bus.addr[11:3] == BASE_ADDR[11:3]);
    assign pop_s    = ~empty_s & bus.wr_ready;
    assign status_s = status_byte(3'(count_s), full_s, empty_s);

    // Strobe synchronisers; the edge flop resets low so a strobe held low across reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_s1_r <= 1'b0;
            adr_s2_r <= 1'b0;
            ds1_r    <= 1'b0;
            ds2_r    <= 1'b0;
            ds3_r    <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            adr_s1_r <= bus.adrstb_n;
            adr_s2_r <= adr_s1_r;
            ds1_r    <= bus.datstb_n;
            ds2_r    <= ds1_r;
            ds3_r    <= ds2_r;
            fall_r   <= ds3_r & ~ds2_r;
        end
    end

    // FIFO push/flush requests; a stalled write replays its captured offset and data.
    always_comb begin
        push_s      = 1'b0;
        flush_s     = 1'b0;
        push_word_s = {pend_off_r, pend_data_r};
        case (state_r)
            ST_DECODE: begin
                if (hit_s && !is_rd_s) begin
                    if (off_s == STATUS_OFFSET) begin
                        flush_s = 1'b1;
                    end else begin
                        push_s      = ~full_s;
                        push_word_s = {off_s, bus.d_in};
                    end
                end else begin
                    push_s = 1'b0;
                end
            end
            ST_WAIT_ROOM: push_s = ~full_s;
            default:      push_s = 1'b0;
        endcase
    end

    vdu_ste_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (11),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_word_s),
        .pop       (pop_s),
        .flush     (flush_s),
        .head_data (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Bus-cycle FSM with registered cs, d_oe, d_out and read offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cs_r        <= 1'b1;
            d_oe_r      <= 1'b0;
            d_out_r     <= 8'h00;
            rd_addr_r   <= 3'd0;
            pend_off_r  <= 3'd0;
            pend_data_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cs_r   <= 1'b1;
                    d_oe_r <= 1'b0;
                    if (fall_r) state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    pend_off_r  <= off_s;
                    pend_data_r <= bus.d_in;
                    if (!hit_s) begin
                        state_r <= ST_RELEASE;
                    end else if (is_rd_s) begin
                        if (off_s == STATUS_OFFSET) begin
                            d_out_r <= status_s;
                        end else begin
                            d_out_r   <= bus.rd_data;
                            rd_addr_r <= off_s;
                        end
                        cs_r    <= 1'b0;
                        d_oe_r  <= 1'b1;
                        state_r <= ST_ACTIVE;
                    end else if ((off_s == STATUS_OFFSET) || !full_s) begin
                        cs_r    <= 1'b0;
                        state_r <= ST_ACTIVE;
                    end else begin
                        state_r <= ST_WAIT_ROOM;
                    end
                end
                ST_WAIT_ROOM: begin
                    if (!full_s) begin
                        cs_r    <= 1'b0;
                        state_r <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (ds2_r) begin
                        cs_r    <= 1'b1;
                        d_oe_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    if (ds2_r) state_r <= ST_IDLE;
                end
                default: begin
                    cs_r    <= 1'b1;
                    d_oe_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // The controller sees the live offset while decoding so rd_data is ready in the same cycle.
    assign bus.rd_addr  = (state_r == ST_DECODE) ? off_s : rd_addr_r;
    assign bus.cs       = cs_r;
    assign bus.d_oe     = d_oe_r;
    assign bus.d_out    = d_out_r;
    assign bus.wr_valid = ~empty_s;
    assign bus.wr_addr  = head_s[10:8];
    assign bus.wr_data  = head_s[7:0];

endmodule

// File: doc/vdu_ste_slave.md
# vdu_ste_slave

STEbus slave front end for the VDU card. It sits directly upstream of the DATACK acknowledge generator and drives that block's active-low `cs`. The block does four things:
- decodes I/O cycles addressed to the card;
- queues register writes in a 4-entry FIFO toward the video controller;
- serves register reads and a local status register;
- stretches the bus cycle by withholding `cs` while the FIFO is full.

## Interface
Parameters:
- BASE_ADDR, 12'h0A0: I/O base of the 8-byte register window. Only bits [11:3] are compared.
- FIFO_DEPTH, 4: write FIFO depth. Must be a power of two, maximum 8.

Ports (name, direction, width, meaning):
- clk, in, 1: 16 MHz bus clock. All logic is on the posedge.
- rst_n, in, 1: reset, asynchronous and active-low.
- adrstb_n, in, 1: STEbus ADRSTB*, asynchronous.
- datstb_n, in, 1: STEbus DATSTB*, asynchronous.
- cm, in, 3: STEbus CM2..CM0. 3'b10x = I/O cycle; CM0=1 is a read, CM0=0 is a write.
- addr, in, 12: STEbus A11..A0.
- d_in, in, 8: STEbus write data.
- d_out, out, 8: read data toward the bus transceiver.
- d_oe, out, 1: transceiver output enable, active high.
- cs, out, 1: card select to the acknowledge generator, active low.
- wr_valid, out, 1: FIFO head is valid.
- wr_addr, out, 3: register offset at the FIFO head.
- wr_data, out, 8: data at the FIFO head.
- wr_ready, in, 1: the video controller pops the head when wr_valid && wr_ready.
- rd_addr, out, 3: register offset being read.
- rd_data, in, 8: combinational read data from the controller for rd_addr.

## Operation
- Synchronisation:
  - adrstb_n and datstb_n each pass through 2 flops.
  - A third datstb flop detects edges. It resets to 0, so a strobe already low when reset is released is not a falling edge.
  - addr, cm and d_in are sampled only in DECODE. The bus holds them stable while the strobe is low.
- Hit condition: synced adrstb low, cm[2:1]==2'b10, and addr[11:3]==BASE_ADDR[11:3].
- FSM states are IDLE, DECODE, WAIT_ROOM, ACTIVE and RELEASE.
  - IDLE: on a synced datstb falling edge, go to DECODE.
  - DECODE, no hit: go to RELEASE. cs never asserts.
  - DECODE, read, offset 7: d_out is loaded with the status byte {3'b0, count[2:0], full, empty}. Go to ACTIVE.
  - DECODE, read, offsets 0–6: rd_addr = offset and d_out <= rd_data. Go to ACTIVE.
  - DECODE, write, offset 7: flush the FIFO (count=0, pointers=0; d_in ignored). Go to ACTIVE.
  - DECODE, write, offsets 0–6, FIFO not full: push {offset, d_in}. Go to ACTIVE.
  - DECODE, write, offsets 0–6, FIFO full: go to WAIT_ROOM.
  - WAIT_ROOM: cs is held high, which stretches the bus cycle. On the first cycle with count < FIFO_DEPTH, push and go to ACTIVE.
  - ACTIVE: cs=0, and d_oe=1 for reads. When synced datstb is high, go to IDLE with cs=1 and d_oe=0.
  - RELEASE: wait for synced datstb high, then go to IDLE.
- FIFO:
  - Circular buffer with a count of width clog2(FIFO_DEPTH)+1 and pointers that wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle leave count unchanged. When full, such a simultaneous push and pop is legal only from WAIT_ROOM after room appears, because push is gated on !full.
  - A flush in the same cycle as a pop: the flush wins.
  - wr_valid = (count != 0). The head outputs are registered from the FIFO array.
- Reset (asynchronous, any state): state=IDLE, cs=1, d_oe=0, d_out=8'h00, rd_addr=0, FIFO empty, wr_valid=0, synchroniser flops=0.
  - A reset mid-cycle drops cs. The bus cycle is then not acknowledged; the master times out.

## Timing
- cs changes on the clk posedge. The acknowledge generator samples it on the following negedge, giving half a cycle of setup.
- A datstb_n falling edge that meets setup before posedge k gives:
  - edge detected at k+2;
  - DECODE at k+3;
  - cs low and d_oe high from k+4.
- cs stays low until 1 cycle after synced datstb is seen high: 3 cycles after datstb_n rises.
- Minimum cs-low width is ≥2 cycles, because the master holds datstb until DATACK. This satisfies the acknowledge generator's 2-state sequence.
- d_out is stable for the whole time d_oe is high.
- A FIFO push becomes visible on wr_valid the cycle after DECODE or WAIT_ROOM.

## Structure
- Package vdu_ste_pkg:
  - CM_IO = 3'b100 and the CM read bit index;
  - STATUS_OFFSET = 3'd7;
  - the FSM state enum;
  - the status-byte bit positions.
- Sub-module vdu_ste_fifo: a parameterised synchronous FIFO with push, pop, flush, count, full and empty, instantiated once. The bus-side FSM and decode stay in vdu_ste_slave.

## Test plan
- Write 8'h5A to BASE+2: cs low at k+4, wr_valid rises with wr_addr=2 and wr_data=8'h5A, and cs high 3 cycles after datstb_n rises.
- Read BASE+1 with rd_data=8'hC3: d_oe=1 and d_out=8'hC3 while cs is low. After the strobe is released, d_oe=0.
- Hold wr_ready=0 and do 5 writes: the 5th cycle sits in WAIT_ROOM with cs=1. Pulse wr_ready for 1 cycle: the push completes and cs goes low. Read of BASE+7 returns 8'h12 (count=4, full=1).
- Access address 12'h0B0 and an access with cm=3'b110: cs stays 1 throughout and the FIFO is unchanged.
- With 3 entries queued, write BASE+7: count=0 and wr_valid=0 in the next cycle. Read of BASE+7 returns 8'h01.
- Assert rst_n=0 with cs low mid-write, then release it with datstb_n still low: cs=1 and no push occur. A new cycle is accepted only after datstb_n goes high and falls again.
